// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store unit definitions: op encodings, FSM states and
// byte-lane sizing helpers used by the controller and its aligner.
package lsu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LD_B  = 4'b0000,
    OP_LD_H  = 4'b0001,
    OP_LD_W  = 4'b0010,
    OP_ST_B  = 4'b0100,
    OP_ST_H  = 4'b0101,
    OP_ST_W  = 4'b0110,
    OP_LD_BU = 4'b1000,
    OP_LD_HU = 4'b1001
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic int strb_bits(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    case (op)
      OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    case (op)
      OP_ST_B, OP_ST_H, OP_ST_W: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // op[1:0] encodes the access size for every legal load/store
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op[1:0])
      2'b01:   return lo[0];
      2'b10:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data replication and load extract/extend
// for a little-endian DATA_W-wide bus.
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB     = strb_bits(DATA_W),
  localparam int LANE_W = lane_bits(DATA_W)
) (
  input  logic [3:0]        op,
  input  logic [LANE_W-1:0] lane,
  input  logic [31:0]       st_src,
  input  logic [DATA_W-1:0] ld_src,
  output logic [NB-1:0]     st_strb,
  output logic [DATA_W-1:0] st_data,
  output logic [31:0]       ld_data
);

  logic [NB-1:0] base;
  logic [31:0]   ld_lane;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  always_comb begin
    base = '0;
    case (op[1:0])
      2'b00:   base[0]   = 1'b1;
      2'b01:   base[1:0] = 2'b11;
      default: base[3:0] = 4'hF;
    endcase
    st_strb = op_is_store(op) ? (base << lane) : '0;

    // replicate so the addressed lane carries the data whatever its offset
    case (op[1:0])
      2'b00:   st_data = {NB{st_src[7:0]}};
      2'b01:   st_data = {(NB/2){st_src[15:0]}};
      default: st_data = {(NB/4){st_src}};
    endcase

    ld_lane = 32'(ld_src >> {lane, 3'b000});
    case (op)
      OP_LD_B:  ld_data = ext8(ld_lane[7:0], 1'b1);
      OP_LD_BU: ld_data = ext8(ld_lane[7:0], 1'b0);
      OP_LD_H:  ld_data = ext16(ld_lane[15:0], 1'b1);
      OP_LD_HU: ld_data = ext16(ld_lane[15:0], 1'b0);
      OP_LD_W:  ld_data = ld_lane;
      default:  ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between EX and a grant/rvalid
// memory bus, with misalignment detection, bus timeout and flush.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          lsu_op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  output logic                resp_valid,
  output logic [31:0]         rdata,
  output logic                exc_misalign,
  output logic                exc_bus,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                flush
);

  localparam int NB     = strb_bits(DATA_W);
  localparam int LANE_W = lane_bits(DATA_W);
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              bus_q, bus_d;
  logic              hs;

  logic [NB-1:0]     st_strb;
  logic [DATA_W-1:0] st_data;
  logic [31:0]       ld_data;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .op      (op_q),
    .lane    (addr_q[LANE_W-1:0]),
    .st_src  (wdata_q),
    .ld_src  (mem_rdata),
    .st_strb (st_strb),
    .st_data (st_data),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    bus_d   = bus_q;
    hs      = req_valid && (state_q == ST_IDLE) && !flush;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          rdata_d = '0;
          mis_d   = 1'b0;
          bus_d   = 1'b0;
          // NOPs and misaligned accesses complete without touching the bus
          if (!op_is_load(lsu_op) && !op_is_store(lsu_op)) begin
            state_d = ST_RESP;
          end else if (op_misaligned(lsu_op, addr[1:0])) begin
            mis_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            op_d    = lsu_op;
            addr_d  = addr;
            wdata_d = wdata;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_gnt) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_rvalid) begin
          rdata_d = op_is_load(op_q) ? ld_data : '0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          bus_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      bus_q   <= bus_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = (state_q == ST_RESP);
  assign rdata        = resp_valid ? rdata_q : '0;
  assign exc_misalign = resp_valid & mis_q;
  assign exc_bus      = resp_valid & bus_q;

  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & op_is_store(op_q);
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem_wstrb = mem_we ? st_strb : '0;
  assign mem_wdata = mem_we ? st_data : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: 32-bit instance driven through a scoreboard
// of expected responses, plus a 64-bit instance for wide-lane cases.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        bus;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, flush, mem_gnt, mem_rvalid;
  logic [3:0]  lsu_op;
  logic [31:0] addr, wdata, mem_rdata;
  logic        req_ready, resp_valid, exc_misalign, exc_bus, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        b_req_valid, b_flush, b_mem_gnt, b_mem_rvalid;
  logic [3:0]  b_lsu_op;
  logic [31:0] b_addr, b_wdata;
  logic [63:0] b_mem_rdata;
  logic        b_req_ready, b_resp_valid, b_exc_misalign, b_exc_bus, b_mem_req, b_mem_we;
  logic [31:0] b_rdata, b_mem_addr;
  logic [63:0] b_mem_wdata;
  logic [7:0]  b_mem_wstrb;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .lsu_op(lsu_op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
    .rdata(rdata), .exc_misalign(exc_misalign), .exc_bus(exc_bus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .flush(flush)
  );

  lsu_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .lsu_op(b_lsu_op), .addr(b_addr), .wdata(b_wdata), .resp_valid(b_resp_valid),
    .rdata(b_rdata), .exc_misalign(b_exc_misalign), .exc_bus(b_exc_bus),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb),
    .mem_wdata(b_mem_wdata), .mem_gnt(b_mem_gnt), .mem_rvalid(b_mem_rvalid),
    .mem_rdata(b_mem_rdata), .flush(b_flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] r, input logic m, input logic b);
    exp_t e;
    e.rdata = r;
    e.mis   = m;
    e.bus   = b;
    sb.push_back(e);
  endtask

  // gd/rd: cycles before grant/rvalid in their phase; rd < 0 never answers
  task automatic txn32(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] mrd, input int gd, input int rd,
                       input bit traffic, input bit e_we, input logic [31:0] e_maddr,
                       input logic [3:0] e_strb, input logic [31:0] e_wdata, input int e_lat);
    int   cyc;
    int   ph_cnt;
    bit   in_wait;
    bit   seen_req;
    bit   done;
    exp_t e;
    chk({tag, "/ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; lsu_op = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; lsu_op = 4'b0011; addr = '0; wdata = '0;
    cyc = 1; ph_cnt = 0; in_wait = 0; seen_req = 0; done = 0;
    while (!done && cyc < 64) begin
      if (resp_valid) begin
        done = 1;
        chk({tag, "/sb_depth"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "/rdata"}, 64'(rdata), 64'(e.rdata));
          chk({tag, "/exc_misalign"}, 64'(exc_misalign), 64'(e.mis));
          chk({tag, "/exc_bus"}, 64'(exc_bus), 64'(e.bus));
        end
        chk({tag, "/latency"}, 64'(cyc), 64'(e_lat));
        chk({tag, "/mem_req_in_resp"}, 64'(mem_req), 64'd0);
      end else begin
        if (!traffic) begin
          chk({tag, "/no_mem_req"}, 64'(mem_req), 64'd0);
        end else if (!in_wait) begin
          chk({tag, "/mem_req"}, 64'(mem_req), 64'd1);
          if (!seen_req) begin
            seen_req = 1;
            chk({tag, "/mem_addr"}, 64'(mem_addr), 64'(e_maddr));
            chk({tag, "/mem_we"}, 64'(mem_we), 64'(e_we));
            if (e_we) begin
              chk({tag, "/mem_wstrb"}, 64'(mem_wstrb), 64'(e_strb));
              chk({tag, "/mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
            end
          end
          mem_gnt = (ph_cnt >= gd);
        end else begin
          mem_rvalid = (rd >= 0) && (ph_cnt >= rd);
          mem_rdata  = mrd;
        end
        @(posedge clk); #1;
        cyc++;
        if (mem_gnt && !in_wait) begin
          in_wait = 1;
          ph_cnt  = 0;
        end else begin
          ph_cnt++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
    end
    chk({tag, "/resp_seen"}, 64'(done), 64'd1);
    @(posedge clk); #1;
    chk({tag, "/pulse_end"}, 64'(resp_valid), 64'd0);
    chk({tag, "/ready_after"}, 64'(req_ready), 64'd1);
  endtask

  task automatic txn64(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [63:0] mrd, input bit is_st,
                       input logic [7:0] e_strb, input logic [63:0] e_wdata, input logic [31:0] e_rdata);
    b_req_valid = 1'b1; b_lsu_op = op; b_addr = a; b_wdata = wd;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk({tag, "/mem_req"}, 64'(b_mem_req), 64'd1);
    chk({tag, "/mem_addr"}, 64'(b_mem_addr), 64'(a & 32'hFFFF_FFF8));
    if (is_st) begin
      chk({tag, "/mem_wstrb"}, 64'(b_mem_wstrb), 64'(e_strb));
      chk({tag, "/mem_wdata"}, b_mem_wdata, e_wdata);
    end
    b_mem_gnt = 1'b1;
    @(posedge clk); #1;
    b_mem_gnt = 1'b0; b_mem_rvalid = 1'b1; b_mem_rdata = mrd;
    @(posedge clk); #1;
    b_mem_rvalid = 1'b0;
    chk({tag, "/resp_valid"}, 64'(b_resp_valid), 64'd1);
    chk({tag, "/rdata"}, 64'(b_rdata), 64'(e_rdata));
    @(posedge clk); #1;
  endtask

  initial begin
    req_valid = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0;
    lsu_op = 4'b0011; addr = '0; wdata = '0; mem_rdata = '0;
    b_req_valid = 0; b_flush = 0; b_mem_gnt = 0; b_mem_rvalid = 0;
    b_lsu_op = 4'b0011; b_addr = '0; b_wdata = '0; b_mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/req_ready", 64'(req_ready), 64'd1);
    chk("rst/resp_valid", 64'(resp_valid), 64'd0);
    chk("rst/mem_req", 64'(mem_req), 64'd0);
    chk("rst/mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst/rdata", 64'(rdata), 64'd0);
    chk("rst64/req_ready", 64'(b_req_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push(32'h0, 1'b0, 1'b0);
    txn32("st_b", OP_ST_B, 32'h1C00_0003, 32'h0000_00AB, 32'h0, 0, 0, 1, 1,
          32'h1C00_0000, 4'b1000, 32'hABAB_ABAB, 3);
    push(32'hFFFF_FF80, 1'b0, 1'b0);
    txn32("ld_b", OP_LD_B, 32'h2, 32'h0, 32'h0080_0000, 1, 2, 1, 0,
          32'h0, 4'h0, 32'h0, 6);
    push(32'h0000_0080, 1'b0, 1'b0);
    txn32("ld_bu", OP_LD_BU, 32'h2, 32'h0, 32'h0080_0000, 0, 0, 1, 0,
          32'h0, 4'h0, 32'h0, 3);
    push(32'hFFFF_8001, 1'b0, 1'b0);
    txn32("ld_h", OP_LD_H, 32'h2, 32'h0, 32'h8001_0000, 0, 0, 1, 0,
          32'h0, 4'h0, 32'h0, 3);
    push(32'h0000_8001, 1'b0, 1'b0);
    txn32("ld_hu", OP_LD_HU, 32'h2, 32'h0, 32'h8001_0000, 0, 1, 1, 0,
          32'h0, 4'h0, 32'h0, 4);
    push(32'hDEAD_BEEF, 1'b0, 1'b0);
    txn32("ld_w", OP_LD_W, 32'h4, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, 0,
          32'h4, 4'h0, 32'h0, 3);
    push(32'h0, 1'b0, 1'b0);
    txn32("st_h", OP_ST_H, 32'h2, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0, 1, 1,
          32'h0, 4'b1100, 32'h1234_1234, 3);
    push(32'h0, 1'b0, 1'b0);
    txn32("st_w", OP_ST_W, 32'h8, 32'hCAFE_F00D, 32'hFFFF_FFFF, 2, 0, 1, 1,
          32'h8, 4'b1111, 32'hCAFE_F00D, 5);
    push(32'h0, 1'b1, 1'b0);
    txn32("mis_w", OP_LD_W, 32'h6, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1);
    push(32'h0, 1'b1, 1'b0);
    txn32("mis_h", OP_ST_H, 32'h1, 32'h5555, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1);
    push(32'h0, 1'b0, 1'b0);
    txn32("nop", 4'b1111, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1);
    push(32'h0, 1'b0, 1'b1);
    txn32("timeout", OP_LD_W, 32'h40, 32'h0, 32'h1234_5678, 0, -1, 1, 0,
          32'h40, 4'h0, 32'h0, 18);

    // flush while waiting for rvalid, then a stale rvalid
    req_valid = 1'b1; lsu_op = OP_LD_W; addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_wait/req_ready", 64'(req_ready), 64'd1);
    chk("flush_wait/resp_valid", 64'(resp_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rvalid/resp_valid", 64'(resp_valid), 64'd0);
    chk("late_rvalid/mem_req", 64'(mem_req), 64'd0);

    // flush while requesting
    req_valid = 1'b1; lsu_op = OP_LD_W; addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_req/req_ready", 64'(req_ready), 64'd1);
    chk("flush_req/mem_req", 64'(mem_req), 64'd0);

    // flush in IDLE blocks the handshake
    req_valid = 1'b1; lsu_op = OP_LD_W; addr = 32'h300; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle/mem_req", 64'(mem_req), 64'd0);
    chk("flush_idle/req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    chk("flush_idle/resp_valid", 64'(resp_valid), 64'd0);

    // asynchronous reset mid-transaction drops it
    req_valid = 1'b1; lsu_op = OP_ST_W; addr = 32'h400; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst/mem_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst/mem_req", 64'(mem_req), 64'd0);
    chk("async_rst/mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("async_rst/req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst/resp_valid", 64'(resp_valid), 64'd0);

    // 64-bit bus lanes
    txn64("w64_ld_hu", OP_LD_HU, 32'h6, 32'h0, 64'h1234_5678_0000_0000, 0,
          8'h00, 64'h0, 32'h0000_1234);
    txn64("w64_st_b", OP_ST_B, 32'h1000_0005, 32'h0000_00AB, 64'h0, 1,
          8'b0010_0000, 64'hABAB_ABAB_ABAB_ABAB, 32'h0);
    txn64("w64_ld_w", OP_LD_W, 32'h4, 32'h0, 64'h8765_4321_0BAD_F00D, 0,
          8'h00, 64'h0, 32'h8765_4321);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
